alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Iterative, handshaked RV32M-style multiply/divide unit, parametrised in data width N.
- Sits beside the single-cycle integer ALU in the execute stage. Takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations.
- Holds the requesting instruction's destination tag until writeback accepts the result.
- Multi-cycle, so it exposes valid/ready on both sides and a flush input for pipeline squash.

Parameters:
- N, 32, operand and result width (even, ≥8).
- TAG_W, 5, width of the passthrough destination tag.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  N  rs1 operand.
- in_b  in  N  rs2 operand.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  N  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0, async): state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0, all internal registers 0. in_ready=1 once in IDLE.
- Accept when in_valid && in_ready at a rising edge; latch op, operands and tag.
- States and transitions:
  - IDLE → PREP on accept.
  - PREP (1 cycle): record operand signs per op (MULHSU: A signed, B unsigned; *U ops: both unsigned). Take magnitudes. Detect special divide cases. Go to DONE if special, else CALC.
  - CALC (N cycles, counter N-1 down to 0): multiply uses radix-2 shift-add on the 2N-bit product register; divide uses restoring shift-subtract on the {rem, quot} register.
  - FIX (1 cycle): conditional two's-complement negation. Product sign = sA^sB. Quotient sign = sA^sB. Remainder sign = sA. Select low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - DONE: out_valid=1. out_result and out_tag held stable until out_ready. Go to IDLE on out_ready.
- Latency from accept edge to out_valid high:
  - normal: N+3 cycles (35 for N=32);
  - special case: 2 cycles.
- Special divide cases:
  - Divide by zero: quotient = all ones, remainder = in_a (DIV, DIVU, REM, REMU).
  - Signed overflow (DIV/REM with a = -2^(N-1) and b = -1): quotient = a, remainder = 0.
- in_ready is low in every non-IDLE state, including DONE. The next accept happens at the earliest one cycle after the out handshake.
- flush=1 at an edge: state=IDLE, out_valid=0, request discarded. flush has priority over out_ready and over accept. An accept attempted in the same cycle is ignored.
- Async reset mid-operation: immediate return to reset values. No output produced.
- All arithmetic is modulo 2^N for the selected word. MUL low word is identical for signed and unsigned.

Optional Feature:
- Macro: ALU_MULDIV_FAST_MUL_EN.
- Defined: multiply ops bypass CALC. PREP computes the full 2N-bit product with the inferred hardware multiplier and registers it; FIX selects the word. Multiply latency = 3 cycles. Divide behaviour is unchanged.
- Undefined: all ops use the iterative path. Multiply latency = N+3. No multiplier inferred.

Decomposition:
- Add to the shared constants header:
  - MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU funct3 defines;
  - state encodings IDLE/PREP/CALC/FIX/DONE.
- Natural sub-module: cond_negate, width-parametrised (in, neg → neg ? -in : in). Instantiated for the operand magnitudes and for the final sign fix.
- Everything else stays in alu_muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → out_result=0xFFFFFFEB. out_valid asserts 35 cycles after accept (3 with ALU_MULDIV_FAST_MUL_EN). out_tag equals in_tag.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF in 2 cycles. REM a=5, b=0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same → 0.
- Hold out_ready=0 for 5 cycles in DONE → out_result, out_tag and out_valid stable, in_ready=0. Raise out_ready → IDLE next cycle and in_ready=1.
- flush at CALC cycle 10 → no out_valid, in_ready=1 next cycle. Reset asserted mid-CALC → all outputs 0 at once. A new request afterwards completes correctly.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 opcodes and FSM states.
// No logic; imported by alu_muldiv_seq and its sub-modules.
package alu_muldiv_seq_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_cond_negate.sv
// Width-parametrised conditional two's-complement negation (neg ? -in : in).
// Latency: combinational. Backpressure: none.
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M-style multiply/divide unit with tag passthrough; ALU_MULDIV_FAST_MUL_EN gives single-shot multiply.
// Latency accept->out_valid: N+3 edges (3 for fast multiply, 2 for divide-by-zero / signed overflow).
// Backpressure: in_ready only in IDLE; result and tag held in DONE until out_ready; flush aborts.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(N);

    state_t             state;
    logic [2:0]         op_q;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               sa_q;
    logic               sb_q;
    logic [2*N-1:0]     acc;
    logic [CNT_W-1:0]   cnt;

    logic               sign_a;
    logic               sign_b;
    logic [N-1:0]       mag_a;
    logic [N-1:0]       mag_b;
    logic               div_zero;
    logic               div_ovf;
    logic [N-1:0]       special_res;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                sign_a = a_q[N-1];
                sign_b = b_q[N-1];
            end
            OP_MULHSU: sign_a = a_q[N-1];
            default: ;
        endcase
    end

    cond_negate #(.W(N)) u_mag_a (.in_val(a_q), .neg(sign_a), .out_val(mag_a));
    cond_negate #(.W(N)) u_mag_b (.in_val(b_q), .neg(sign_b), .out_val(mag_b));

    assign div_zero = op_is_div(op_q) && (b_q == '0);
    assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM))
                      && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        if (div_zero)
            special_res = op_is_rem(op_q) ? a_q : '1;
        else
            special_res = op_is_rem(op_q) ? '0 : a_q;
    end

    // One iteration step: acc holds {hi, lo}; multiply shifts the partial sum in
    // from the top, divide shifts the dividend out into the remainder.
    logic [N:0]     mul_sum;
    logic [N:0]     div_part;
    logic [N:0]     div_diff;
    logic           div_ge;
    logic [N-1:0]   div_hi;
    logic [2*N-1:0] calc_next;

    assign mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? b_q : {N{1'b0}})};
    assign div_part  = acc[2*N-1:N-1];
    assign div_ge    = div_part >= {1'b0, b_q};
    assign div_diff  = div_part - {1'b0, b_q};
    assign div_hi    = div_ge ? div_diff[N-1:0] : div_part[N-1:0];
    assign calc_next = op_is_div(op_q) ? {div_hi, acc[N-2:0], div_ge}
                                       : {mul_sum, acc[N-1:1]};

    // Final sign fix shares one 2N-bit negator: product, or zero-extended quotient/remainder.
    logic [2*N-1:0] fix_in;
    logic           fix_neg;
    logic [2*N-1:0] fix_out;
    logic [N-1:0]   fix_word;

    always_comb begin
        if (!op_is_div(op_q))
            fix_in = acc;
        else if (op_is_rem(op_q))
            fix_in = {{N{1'b0}}, acc[2*N-1:N]};
        else
            fix_in = {{N{1'b0}}, acc[N-1:0]};
    end

    assign fix_neg = op_is_rem(op_q) ? sa_q : (sa_q ^ sb_q);

    cond_negate #(.W(2*N)) u_fix (.in_val(fix_in), .neg(fix_neg), .out_val(fix_out));

    assign fix_word = ((op_q == OP_MUL) || op_is_div(op_q)) ? fix_out[N-1:0]
                                                             : fix_out[2*N-1:N];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        tag_q    <= in_tag;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    sa_q <= sign_a;
                    sb_q <= sign_b;
                    a_q  <= mag_a;
                    b_q  <= mag_b;
                    acc  <= {{N{1'b0}}, mag_a};
                    cnt  <= CNT_W'(N-1);
                    if (div_zero || div_ovf) begin
                        out_result <= special_res;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
`ifdef ALU_MULDIV_FAST_MUL_EN
                    else if (!op_is_div(op_q)) begin
                        acc   <= {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
                        state <= S_FIX;
                    end
`endif
                    else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= calc_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0)
                        state <= S_FIX;
                end
                S_FIX: begin
                    out_result <= fix_word;
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: arithmetic model + scoreboard queue checked every negedge.
// Covers all eight ops, special divide cases, DONE stall, flush and mid-operation reset.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    localparam int N     = 32;
    localparam int TAG_W = 5;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    alu_muldiv_seq #(.N(N), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]     res;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc_cyc;
    } exp_t;
    exp_t exp_q[$];
    bit   first_seen = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference arithmetic straight from the op definitions, using 64-bit integers.
    function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        int     ia = a;
        int     ib = b;
        logic [63:0] p;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        if (!op[2] && FAST) return 3;
        return N + 3;
    endfunction

    // Scoreboard: every cycle out_valid is high the result/tag must match the head entry.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                check("result", {32'b0, out_result}, {32'b0, exp_q[0].res});
                check("tag", {59'b0, out_tag}, {59'b0, exp_q[0].tag});
                check("in_ready_low_in_done", {63'b0, in_ready}, 64'd0);
                check("busy_in_done", {63'b0, busy}, 64'd1);
                if (first_seen) begin
                    check("latency", 64'(cyc - exp_q[0].acc_cyc + 1), 64'(exp_q[0].lat));
                    first_seen = 1'b0;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    first_seen = 1'b1;
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [TAG_W-1:0] tag, input bit push, input logic [N-1:0] lit);
        exp_t e;
        check("in_ready_idle", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (push) begin
            e.res     = model(op, a, b);
            e.tag     = tag;
            e.lat     = exp_latency(op, a, b);
            e.acc_cyc = cyc;
            check("model_pin", {32'b0, e.res}, {32'b0, lit});
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int hold);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!out_valid) begin
            check("timeout_out_valid", {63'b0, out_valid}, 64'd1);
            exp_q.delete();
            first_seen = 1'b1;
            return;
        end
        repeat (hold) begin
            @(posedge clock); #1;
        end
        check("valid_held", {63'b0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("in_ready_after_handshake", {63'b0, in_ready}, 64'd1);
        check("valid_dropped", {63'b0, out_valid}, 64'd0);
        check("busy_dropped", {63'b0, busy}, 64'd0);
    endtask

    task automatic run(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [N-1:0] lit, input int hold);
        issue(op, a, b, tag, 1'b1, lit);
        wait_done(hold);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_result", {32'b0, out_result}, 64'd0);
        check("rst_out_tag", {59'b0, out_tag}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        run(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 0);
        run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 0);
        run(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 0);
        run(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 0);
        run(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 0);
        run(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 0);
        run(OP_DIVU,   32'd100,       32'd7,         5'd9,  32'd14,        0);
        run(OP_REMU,   32'd100,       32'd7,         5'd10, 32'd2,         5);
        run(OP_DIVU,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 0);
        run(OP_REM,    32'd5,         32'd0,         5'd12, 32'd5,         0);
        run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
        run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 3);
        run(OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 32'h0B00_EA4E, 0);
        run(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 0);

        // Flush during divide iterations: nothing may come out.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd17, 1'b0, 32'd0);
        repeat (10) begin
            @(posedge clock); #1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_valid", {63'b0, out_valid}, 64'd0);
        check("flush_in_ready", {63'b0, in_ready}, 64'd1);
        check("flush_busy", {63'b0, busy}, 64'd0);
        repeat (45) begin
            @(posedge clock); #1;
        end
        check("flush_no_late_valid", {63'b0, out_valid}, 64'd0);

        // Accept attempted together with flush is dropped.
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd3; flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {63'b0, busy}, 64'd0);

        // Async reset in the middle of a divide clears outputs immediately.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd18, 1'b0, 32'd0);
        repeat (10) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_out_result", {32'b0, out_result}, 64'd0);
        check("midrst_out_tag", {59'b0, out_tag}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd19, 32'hFFFF_FFF2, 0);
        run(OP_MUL, 32'h0001_0000, 32'h0001_0003, 5'd20, 32'h0003_0000, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
